// File: rtl/vliw_pkg.sv
// Shared opcode encodings, slot field positions and slot-kind type for the
// VLIW issue controller and its per-slot decoders.
package vliw_pkg;

  localparam logic [2:0] OP_LOAD  = 3'b000;
  localparam logic [2:0] OP_AND   = 3'b001;
  localparam logic [2:0] OP_OR    = 3'b010;
  localparam logic [2:0] OP_XOR   = 3'b011;
  localparam logic [2:0] OP_STORE = 3'b100;
  localparam logic [2:0] OP_ADD   = 3'b101;
  localparam logic [2:0] OP_SUB   = 3'b110;
  localparam logic [2:0] OP_MUL   = 3'b111;

  localparam int SLOT_W = 16;
  localparam int OPC_HI = 15;
  localparam int OPC_LO = 13;
  localparam int RD_HI  = 12;
  localparam int RD_LO  = 10;
  localparam int RS1_HI = 9;
  localparam int RS1_LO = 7;
  localparam int RS2_HI = 6;
  localparam int RS2_LO = 4;

  typedef enum logic {SLOT_ALU, SLOT_MEM} slot_kind_e;

  function automatic logic is_alu_op(input logic [2:0] op);
    return op inside {OP_AND, OP_OR, OP_XOR, OP_ADD, OP_SUB, OP_MUL};
  endfunction

endpackage

// File: rtl/vliw_slot_decode.sv
// Combinational decoder for one bundle slot. o_we is the slot's write-port
// enable: register write in an ALU slot, memory write (store) in a memory slot.
module vliw_slot_decode
  import vliw_pkg::*;
#(
  parameter slot_kind_e KIND = SLOT_ALU
) (
  input  logic [SLOT_W-1:0] i_word,
  output logic              o_we,
  output logic              o_is_load,
  output logic              o_is_store,
  output logic [2:0]        o_rd,
  output logic              o_src1_vld,
  output logic [2:0]        o_src1,
  output logic              o_src2_vld,
  output logic [2:0]        o_src2
);

  logic [2:0] w_op;

  always_comb begin
    w_op       = i_word[OPC_HI:OPC_LO];
    o_we       = 1'b0;
    o_is_load  = 1'b0;
    o_is_store = 1'b0;
    o_rd       = i_word[RD_HI:RD_LO];
    o_src1_vld = 1'b0;
    o_src1     = i_word[RS1_HI:RS1_LO];
    o_src2_vld = 1'b0;
    o_src2     = i_word[RS2_HI:RS2_LO];
    if (KIND == SLOT_ALU) begin
      if (is_alu_op(w_op)) begin
        o_we       = 1'b1;
        o_src1_vld = 1'b1;
        o_src2_vld = 1'b1;
      end
    end else begin
      // A memory-slot word of all zeros is a NOP, not a load of r0
      if (w_op == OP_LOAD && i_word != '0) begin
        o_is_load  = 1'b1;
        o_src1_vld = 1'b1;
      end else if (w_op == OP_STORE) begin
        o_we       = 1'b1;
        o_is_store = 1'b1;
        o_src1_vld = 1'b1;
        o_src2_vld = 1'b1;
        o_src2     = i_word[RD_HI:RD_LO];
      end
    end
  end

endmodule

// File: rtl/vliw_issue_ctrl.sv
// VLIW issue controller: accepts one bundle per cycle, registers write enables,
// tracks in-flight loads per register and stalls fetch on load-use/WAW hazards.
module vliw_issue_ctrl
  import vliw_pkg::*;
#(
  parameter int NUM_ALU  = 2,
  parameter int NUM_MEM  = 1,
  parameter int REG_W    = 3,
  parameter int LOAD_LAT = 2
) (
  input  logic                               i_clk,
  input  logic                               i_rst,
  input  logic                               i_bundle_valid,
  input  logic [SLOT_W*(NUM_ALU+NUM_MEM)-1:0] i_bundle,
  output logic                               o_bundle_ready,
  output logic                               o_out_valid,
  output logic [NUM_ALU-1:0]                 o_alu_we,
  output logic [REG_W*NUM_ALU-1:0]           o_alu_rd,
  output logic [NUM_MEM-1:0]                 o_st_we,
  output logic [2**REG_W-1:0]                o_ld_wb_mask,
  output logic                               o_waw_conflict,
  output logic [15:0]                        o_stall_cycles
);

  localparam int NSLOT = NUM_ALU + NUM_MEM;
  localparam int NREGS = 2**REG_W;
  localparam logic [2:0] CNT_LOAD = 3'(LOAD_LAT + 1);

  logic [NSLOT-1:0]         w_we, w_is_load, w_is_store, w_s1v, w_s2v;
  logic [NSLOT-1:0]         w_dst_vld, w_keep;
  logic [2:0]               w_rd   [NSLOT];
  logic [2:0]               w_src1 [NSLOT];
  logic [2:0]               w_src2 [NSLOT];
  logic                     w_hazard, w_conflict, w_accept;
  logic [REG_W*NUM_ALU-1:0] w_alu_rd_next;

  logic [2:0]               r_cnt [NREGS];
  logic                     r_out_valid, r_waw;
  logic [NUM_ALU-1:0]       r_alu_we;
  logic [REG_W*NUM_ALU-1:0] r_alu_rd;
  logic [NUM_MEM-1:0]       r_st_we;
  logic [15:0]              r_stall;

  for (genvar s = 0; s < NSLOT; s++) begin : g_slot
    vliw_slot_decode #(
      .KIND(slot_kind_e'((s < NUM_ALU) ? SLOT_ALU : SLOT_MEM))
    ) u_dec (
      .i_word    (i_bundle[SLOT_W*s +: SLOT_W]),
      .o_we      (w_we[s]),
      .o_is_load (w_is_load[s]),
      .o_is_store(w_is_store[s]),
      .o_rd      (w_rd[s]),
      .o_src1_vld(w_s1v[s]),
      .o_src1    (w_src1[s]),
      .o_src2_vld(w_s2v[s]),
      .o_src2    (w_src2[s])
    );
  end

  for (genvar a = 0; a < NUM_ALU; a++) begin : g_alu_rd
    assign w_alu_rd_next[REG_W*a +: REG_W] = REG_W'(w_rd[a]);
  end

  assign w_dst_vld = (w_we & ~w_is_store) | w_is_load;

  // A register with cnt==1 writes back this cycle and the file writes through
  always_comb begin
    w_hazard = 1'b0;
    for (int s = 0; s < NSLOT; s++) begin
      if (w_s1v[s] && r_cnt[REG_W'(w_src1[s])] > 3'd1) w_hazard = 1'b1;
      if (w_s2v[s] && r_cnt[REG_W'(w_src2[s])] > 3'd1) w_hazard = 1'b1;
      if (w_dst_vld[s] && r_cnt[REG_W'(w_rd[s])] > 3'd1) w_hazard = 1'b1;
    end
  end

  // The highest-indexed writer of a destination wins; lower ones are dropped
  always_comb begin
    w_keep     = '0;
    w_conflict = 1'b0;
    for (int s = 0; s < NSLOT; s++) begin
      if (w_dst_vld[s]) begin
        w_keep[s] = 1'b1;
        for (int j = s + 1; j < NSLOT; j++) begin
          if (w_dst_vld[j] && w_rd[j] == w_rd[s]) w_keep[s] = 1'b0;
        end
        if (!w_keep[s]) w_conflict = 1'b1;
      end
    end
  end

  assign o_bundle_ready = !w_hazard;
  assign w_accept       = i_bundle_valid && o_bundle_ready;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_out_valid <= 1'b0;
      r_alu_we    <= '0;
      r_alu_rd    <= '0;
      r_st_we     <= '0;
      r_waw       <= 1'b0;
    end else if (w_accept) begin
      r_out_valid <= 1'b1;
      r_alu_we    <= w_we[NUM_ALU-1:0] & w_keep[NUM_ALU-1:0];
      r_alu_rd    <= w_alu_rd_next;
      r_st_we     <= w_we[NSLOT-1:NUM_ALU];
      r_waw       <= w_conflict;
    end else begin
      r_out_valid <= 1'b0;
      r_alu_we    <= '0;
      r_st_we     <= '0;
      r_waw       <= 1'b0;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int r = 0; r < NREGS; r++) r_cnt[r] <= '0;
    end else begin
      for (int r = 0; r < NREGS; r++) begin
        if (r_cnt[r] != 3'd0) r_cnt[r] <= r_cnt[r] - 3'd1;
        for (int s = 0; s < NSLOT; s++) begin
          if (w_accept && w_is_load[s] && w_keep[s] && REG_W'(w_rd[s]) == REG_W'(r))
            r_cnt[r] <= CNT_LOAD;
        end
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) r_stall <= '0;
    else if (i_bundle_valid && !o_bundle_ready && r_stall != 16'hFFFF) r_stall <= r_stall + 16'd1;
  end

  always_comb begin
    o_ld_wb_mask = '0;
    for (int r = 0; r < NREGS; r++) o_ld_wb_mask[r] = (r_cnt[r] == 3'd1);
  end

  assign o_out_valid    = r_out_valid;
  assign o_alu_we       = r_alu_we;
  assign o_alu_rd       = r_alu_rd;
  assign o_st_we        = r_st_we;
  assign o_waw_conflict = r_waw;
  assign o_stall_cycles = r_stall;

endmodule

// File: tb/tb_vliw_issue_ctrl.sv
// Self-checking bench for vliw_issue_ctrl: scoreboarded issue checks on a default
// instance, plus a LOAD_LAT=6 instance driven into stall-counter saturation.
module tb_vliw_issue_ctrl;
  import vliw_pkg::*;

  localparam int BW     = 48;
  localparam int BUDGET = 50;

  typedef struct packed {
    logic [1:0] aluWe;
    logic [5:0] aluRd;
    logic       stWe;
    logic       waw;
  } expT;

  logic clk = 1'b0, rst = 1'b1, bundleValid = 1'b0, satValid = 1'b0;
  logic [BW-1:0] bundleIn = '0, satBundle = '0;
  logic bundleReady, outValid, stWe, waw;
  logic [1:0] aluWe;
  logic [5:0] aluRd;
  logic [7:0] ldMask;
  logic [15:0] stallCycles;
  logic satReady, satOutValid, satStWe, satWaw;
  logic [1:0] satAluWe;
  logic [5:0] satAluRd;
  logic [7:0] satMask;
  logic [15:0] satStall;

  expT expQ[$];
  logic [7:0] maskSeen[$];
  int checks = 0, errors = 0;

  always #5 clk = ~clk;

  vliw_issue_ctrl dut (
    .i_clk(clk), .i_rst(rst), .i_bundle_valid(bundleValid), .i_bundle(bundleIn),
    .o_bundle_ready(bundleReady), .o_out_valid(outValid), .o_alu_we(aluWe),
    .o_alu_rd(aluRd), .o_st_we(stWe), .o_ld_wb_mask(ldMask),
    .o_waw_conflict(waw), .o_stall_cycles(stallCycles)
  );

  vliw_issue_ctrl #(.LOAD_LAT(6)) dutSat (
    .i_clk(clk), .i_rst(rst), .i_bundle_valid(satValid), .i_bundle(satBundle),
    .o_bundle_ready(satReady), .o_out_valid(satOutValid), .o_alu_we(satAluWe),
    .o_alu_rd(satAluRd), .o_st_we(satStWe), .o_ld_wb_mask(satMask),
    .o_waw_conflict(satWaw), .o_stall_cycles(satStall)
  );

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, actual, expected);
    end
  endtask

  function automatic logic [15:0] slotWord(input logic [2:0] op, input logic [2:0] rd,
                                           input logic [2:0] rs1, input logic [2:0] rs2);
    return {op, rd, rs1, rs2, 4'b0000};
  endfunction

  // Called in the low clock phase; returns at the negedge after the accept edge
  task automatic applyStimulus(input string tag, input logic [BW-1:0] b, input expT e, output int waited);
    waited = 0;
    bundleValid = 1'b1;
    bundleIn = b;
    #1;
    while (!bundleReady && waited < BUDGET) begin
      maskSeen.push_back(ldMask);
      @(negedge clk);
      #1;
      waited++;
    end
    if (!bundleReady) begin
      checkOutput({tag, "_acceptTimeout"}, 32'd0, 32'd1);
      bundleValid = 1'b0;
      bundleIn = '0;
      return;
    end
    maskSeen.push_back(ldMask);
    @(posedge clk);
    expQ.push_back(e);
    @(negedge clk);
    bundleValid = 1'b0;
    bundleIn = '0;
  endtask

  task automatic checkIssue(input string tag);
    expT e;
    if (expQ.size() == 0) begin
      checkOutput({tag, "_queueEmpty"}, 32'd0, 32'd1);
      return;
    end
    e = expQ.pop_front();
    checkOutput({tag, "_outValid"}, 32'(outValid), 32'd1);
    checkOutput({tag, "_aluWe"}, 32'(aluWe), 32'(e.aluWe));
    checkOutput({tag, "_aluRd"}, 32'(aluRd), 32'(e.aluRd));
    checkOutput({tag, "_stWe"}, 32'(stWe), 32'(e.stWe));
    checkOutput({tag, "_waw"}, 32'(waw), 32'(e.waw));
  endtask

  task automatic watchMask(input string tag, input int n);
    logic [7:0] acc;
    acc = '0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      acc |= ldMask;
    end
    checkOutput(tag, 32'(acc), 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int w;
    logic [7:0] expMask [3];
    expMask = '{8'h00, 8'h00, 8'h08};

    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    checkOutput("rst_outValid", 32'(outValid), 32'd0);
    checkOutput("rst_aluWe", 32'(aluWe), 32'd0);
    checkOutput("rst_aluRd", 32'(aluRd), 32'd0);
    checkOutput("rst_stWe", 32'(stWe), 32'd0);
    checkOutput("rst_mask", 32'(ldMask), 32'd0);
    checkOutput("rst_waw", 32'(waw), 32'd0);
    checkOutput("rst_stall", 32'(stallCycles), 32'd0);
    checkOutput("rst_ready", 32'(bundleReady), 32'd1);

    // ADD rd1, SUB rd2, STORE
    applyStimulus("t2", {slotWord(OP_STORE, 3'd5, 3'd6, 3'd0), slotWord(OP_SUB, 3'd2, 3'd3, 3'd4),
                         slotWord(OP_ADD, 3'd1, 3'd2, 3'd3)}, '{2'b11, {3'd2, 3'd1}, 1'b1, 1'b0}, w);
    checkOutput("t2_wait", 32'(w), 32'd0);
    checkIssue("t2");
    checkOutput("t2_ready", 32'(bundleReady), 32'd1);

    // LOAD r3 then a load-use ADD
    applyStimulus("t3ld", {slotWord(OP_LOAD, 3'd3, 3'd1, 3'd0), 32'h0}, '{2'b00, 6'd0, 1'b0, 1'b0}, w);
    checkIssue("t3ld");
    maskSeen.delete();
    applyStimulus("t3add", {32'h0, slotWord(OP_ADD, 3'd6, 3'd3, 3'd0)}, '{2'b01, {3'd0, 3'd6}, 1'b0, 1'b0}, w);
    checkOutput("t3_wait", 32'(w), 32'd2);
    checkOutput("t3_maskCount", 32'(maskSeen.size()), 32'd3);
    for (int i = 0; i < 3; i++)
      if (i < maskSeen.size()) checkOutput($sformatf("t3_mask%0d", i), 32'(maskSeen[i]), 32'(expMask[i]));
    checkIssue("t3add");
    checkOutput("t3_maskAfter", 32'(ldMask), 32'd0);
    checkOutput("t3_stall", 32'(stallCycles), 32'd2);

    // Intra-bundle read of a loaded register does not stall; WAW on it does
    applyStimulus("t4ld", {slotWord(OP_LOAD, 3'd7, 3'd2, 3'd0), 16'h0, slotWord(OP_ADD, 3'd1, 3'd7, 3'd0)},
                  '{2'b01, {3'd0, 3'd1}, 1'b0, 1'b0}, w);
    checkOutput("t4_intraWait", 32'(w), 32'd0);
    checkIssue("t4ld");
    applyStimulus("t4waw", {16'h0, slotWord(OP_AND, 3'd7, 3'd0, 3'd0), 16'h0},
                  '{2'b10, {3'd7, 3'd0}, 1'b0, 1'b0}, w);
    checkOutput("t4_wawWait", 32'(w), 32'd2);
    checkIssue("t4waw");
    checkOutput("t4_stall", 32'(stallCycles), 32'd4);

    // Duplicate ALU destinations
    applyStimulus("t5", {16'h0, slotWord(OP_XOR, 3'd5, 3'd1, 3'd2), slotWord(OP_ADD, 3'd5, 3'd3, 3'd4)},
                  '{2'b10, {3'd5, 3'd5}, 1'b0, 1'b1}, w);
    checkIssue("t5");
    @(negedge clk);
    checkOutput("t5_wawPulse", 32'(waw), 32'd0);
    checkOutput("t5_bubble", 32'(outValid), 32'd0);
    checkOutput("t5_bubbleWe", 32'(aluWe), 32'd0);

    // Load in the memory slot outranks an ALU writer of the same register
    applyStimulus("t5b", {slotWord(OP_LOAD, 3'd2, 3'd1, 3'd0), 16'h0, slotWord(OP_MUL, 3'd2, 3'd3, 3'd4)},
                  '{2'b00, {3'd0, 3'd2}, 1'b0, 1'b1}, w);
    checkIssue("t5b");
    @(negedge clk);
    checkOutput("t5b_maskEarly", 32'(ldMask), 32'd0);
    @(negedge clk);
    checkOutput("t5b_maskWb", 32'(ldMask), 32'h04);

    // All-zero bundle and NOP-encoded opcodes
    applyStimulus("t6z", '0, '{2'b00, 6'd0, 1'b0, 1'b0}, w);
    checkIssue("t6z");
    watchMask("t6z_maskQuiet", 4);
    applyStimulus("t6n", {slotWord(OP_AND, 3'd1, 3'd2, 3'd3), slotWord(OP_LOAD, 3'd2, 3'd1, 3'd0),
                          slotWord(OP_STORE, 3'd1, 3'd2, 3'd3)}, '{2'b00, {3'd2, 3'd1}, 1'b0, 1'b0}, w);
    checkIssue("t6n");
    watchMask("t6n_maskQuiet", 4);

    // Reset while a load is in flight
    applyStimulus("t7", {slotWord(OP_LOAD, 3'd4, 3'd0, 3'd1), 32'h0}, '{2'b00, 6'd0, 1'b0, 1'b0}, w);
    checkIssue("t7");
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    checkOutput("t7_outValid", 32'(outValid), 32'd0);
    checkOutput("t7_stall", 32'(stallCycles), 32'd0);
    checkOutput("t7_ready", 32'(bundleReady), 32'd1);
    watchMask("t7_maskDropped", 6);

    // Saturation: a self-WAW load held valid stalls 6 of every 7 cycles
    checkOutput("scoreboardDrained", 32'(expQ.size()), 32'd0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    satValid = 1'b1;
    satBundle = {slotWord(OP_LOAD, 3'd1, 3'd2, 3'd0), 32'h0};
    repeat (700) @(posedge clk);
    @(negedge clk);
    checkOutput("sat_partial", 32'(satStall), 32'd600);
    repeat (76300) @(posedge clk);
    @(negedge clk);
    checkOutput("sat_stall", 32'(satStall), 32'hFFFF);
    checkOutput("sat_mask", 32'(satMask), 32'h02);
    checkOutput("sat_outValid", 32'(satOutValid), 32'd0);
    checkOutput("sat_enables", 32'({satAluWe, satStWe, satWaw, satAluRd}), 32'd0);
    checkOutput("sat_ready", 32'(satReady), 32'd1);
    satValid = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/vliw_issue_ctrl.md
Name: vliw_issue_ctrl

Overview:
- Parametrised successor to the two-slot combinational write-enable decoder.
- Accepts one VLIW bundle per cycle from fetch over a valid/ready handshake, with NUM_ALU ALU slots and NUM_MEM memory slots.
- Registers the per-slot write enables. Tracks in-flight loads in a per-register scoreboard and stalls fetch on load-use and load-WAW hazards.
- Generates delayed load-writeback enables. Sits between fetch and the register-file/data-memory write ports.

Parameters:
- NUM_ALU, 2, number of ALU slots (slots 0..NUM_ALU-1).
- NUM_MEM, 1, number of memory slots (slots NUM_ALU..NUM_ALU+NUM_MEM-1).
- REG_W, 3, register address width; NREGS = 2**REG_W.
- LOAD_LAT, 2, cycles from load issue (out_valid) to writeback; legal range 1..6.

Ports:
- clk  in  1  clock, all state on rising edge.
- rst  in  1  synchronous active-high reset.
- bundle_valid  in  1  fetch has a bundle.
- bundle  in  16*(NUM_ALU+NUM_MEM)  slot i occupies bits [16*i+15:16*i].
- bundle_ready  out  1  combinational; bundle accepted on an edge where valid && ready.
- out_valid  out  1  issue register holds an accepted bundle.
- alu_we  out  NUM_ALU  registered ALU register-write enables.
- alu_rd  out  REG_W*NUM_ALU  registered ALU destinations.
- st_we  out  NUM_MEM  registered store (memory write) enables.
- ld_wb_mask  out  NREGS  bit r high = load writeback to register r this cycle.
- waw_conflict  out  1  registered one-cycle pulse on an intra-bundle duplicate destination.
- stall_cycles  out  16  saturating count of cycles with bundle_valid && !bundle_ready.

Behaviour:
- Reset (synchronous, active-high, dominates everything):
  - out_valid, alu_we, alu_rd, st_we, ld_wb_mask, waw_conflict, stall_cycles all 0.
  - All scoreboard counters 0, so in-flight loads are dropped and no writeback fires after reset.
  - bundle_ready is 1 in the first cycle after reset.
- Slot encoding:
  - opcode [15:13], rd [12:10], rs1 [9:7], rs2 [6:4].
  - An all-zero slot word is a NOP in any slot.
- ALU slots:
  - Opcodes 001 AND, 010 OR, 011 XOR, 101 ADD, 110 SUB, 111 MUL assert alu_we; sources are rs1 and rs2.
  - Opcodes 000 and 100 in an ALU slot act as NOP.
- Memory slots:
  - Nonzero word with opcode 000 is a LOAD: dest rd, source rs1 (address).
  - Opcode 100 is a STORE: asserts st_we; sources are [12:10] (data) and rs1.
  - Any other opcode in a memory slot acts as NOP.
- Scoreboard:
  - One counter per register, 3 bits wide.
  - On the accept edge of a load to rd r, cnt[r] is loaded with LOAD_LAT+1.
  - Each edge, every nonzero cnt decrements by 1.
  - ld_wb_mask[r] = (cnt[r]==1), so writeback lands exactly LOAD_LAT cycles after the cycle the load shows out_valid.
- Hazard (combinational on bundle):
  - bundle_ready = 0 if any non-NOP slot has a source register r with cnt[r] > 1 (load-use).
  - bundle_ready = 0 if any non-NOP slot has a destination register r with cnt[r] > 1 (WAW).
  - cnt[r]==1 does not stall: the register file writes through in that cycle.
  - Intra-bundle reads observe the old register value, so there is no stall within a bundle.
- Issue:
  - On accept: out_valid <= 1 and the enables/rd fields are registered. Latency is 1 cycle.
  - Otherwise out_valid <= 0 and all enables are 0 (a bubble).
  - There is no downstream backpressure.
- Duplicate destinations in one bundle:
  - The highest slot index keeps its enable; lower writers to the same rd are suppressed.
  - waw_conflict pulses for that issue cycle.
- stall_cycles increments on stall cycles and saturates at 0xFFFF.

Decomposition:
- Package vliw_pkg holds:
  - opcode localparams: OP_LOAD=000, OP_AND=001, OP_OR=010, OP_XOR=011, OP_STORE=100, OP_ADD=101, OP_SUB=110, OP_MUL=111;
  - field bit positions;
  - the is_alu_op function.
- One sub-module: vliw_slot_decode, a combinational per-slot decoder, generated once per slot with a slot-kind parameter. Outputs: we, is_load, is_store, rd, src valids/addrs.
- Scoreboard, hazard logic and issue register stay in the top module.

Test Plan:
- Bundle {ADD rd=1, SUB rd=2, STORE} accepted at cycle 0 → cycle 1: out_valid=1, alu_we=2'b11, alu_rd={2,1}, st_we=1, bundle_ready stays 1.
- LOAD rd=3 accepted at cycle 0, LOAD_LAT=2 → ld_wb_mask=8'h08 in cycle 3 only. A following bundle with ADD rs1=3 holds bundle_ready=0 for cycles 1–2, is accepted at cycle 3, and stall_cycles=2.
- Bundle with slot0 ADD rd=5 and slot1 XOR rd=5 → alu_we=2'b10, waw_conflict=1 for one cycle.
- All-zero bundle → out_valid=1, all enables 0, scoreboard unchanged. Memory-slot word 16'h0000 is not treated as LOAD.
- LOAD rd=4 accepted, then rst high in cycle 1 → ld_wb_mask never nonzero, all outputs 0, bundle_ready=1 in the cycle after reset.
- Hold a hazard stall for 70000 cycles → stall_cycles saturates at 16'hFFFF.
